// File: rtl/demux_1x8_32bit_buf_pkg.sv
// Shared constants and helpers for the 1-to-8 registered word distributor.
package demux_1x8_32bit_buf_pkg;

   localparam int unsigned Lanes    = 8;
   localparam int unsigned SelW     = 3;
   localparam int unsigned DefWidth = 32;
   localparam int unsigned DefCntW  = 16;

   typedef logic [SelW-1:0]  lane_sel_t;
   typedef logic [Lanes-1:0] lane_vec_t;

   function automatic lane_vec_t lane_onehot(input lane_sel_t sel);
      lane_vec_t vec;
      vec      = '0;
      vec[sel] = 1'b1;
      return vec;
   endfunction

endpackage

// File: rtl/demux_1x8_32bit_buf_lane_buf.sv
// One-entry output buffer for a single lane: a load wins over a pop, so a full lane
// can be refilled in the same cycle it drains without a bubble.
module demux_1x8_32bit_buf_lane_buf #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_i,
   input  logic             pop_i,
   input  logic [WIDTH-1:0] data_i,
   output logic             valid_o,
   output logic [WIDTH-1:0] data_o
);

   logic             valid_d, valid_q;
   logic [WIDTH-1:0] data_d, data_q;

   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      if (load_i) begin
         valid_d = 1'b1;
         data_d  = data_i;
      end else if (valid_q && pop_i) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end

   assign valid_o = valid_q;
   assign data_o  = data_q;

endmodule

// File: rtl/demux_1x8_32bit_buf.sv
// Registered 1-to-8 distributor: routes each accepted word to one lane (or all lanes on
// broadcast) and counts input handshakes.
module demux_1x8_32bit_buf
   import demux_1x8_32bit_buf_pkg::*;
#(
   parameter int unsigned WIDTH = DefWidth,
   parameter int unsigned CNT_W = DefCntW
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [WIDTH-1:0]       in_data,
   input  logic [SelW-1:0]        in_select,
   input  logic                   in_bcast,
   output logic [Lanes-1:0]       out_valid,
   input  logic [Lanes-1:0]       out_ready,
   output logic [Lanes*WIDTH-1:0] out_data,
   output logic [CNT_W-1:0]       accept_cnt
);

   lane_vec_t        lane_free;
   lane_vec_t        load;
   logic             accept;
   logic [CNT_W-1:0] cnt_d, cnt_q;

   // Broadcast is all-or-nothing, so it waits until every lane can take the word.
   always_comb begin
      lane_free = ~out_valid | out_ready;
      in_ready  = 1'b0;
      if (!rst) begin
         in_ready = in_bcast ? &lane_free : lane_free[in_select];
      end
      accept = in_valid & in_ready;
      load   = '0;
      if (accept) begin
         load = in_bcast ? '1 : lane_onehot(in_select);
      end
   end

   always_comb begin
      cnt_d = cnt_q + CNT_W'(accept);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign accept_cnt = cnt_q;

   for (genvar i = 0; i < Lanes; i++) begin : g_lane
      demux_1x8_32bit_buf_lane_buf #(
         .WIDTH(WIDTH)
      ) u_lane_buf (
         .clk    (clk),
         .rst    (rst),
         .load_i (load[i]),
         .pop_i  (out_ready[i]),
         .data_i (in_data),
         .valid_o(out_valid[i]),
         .data_o (out_data[i*WIDTH +: WIDTH])
      );
   end

endmodule

// File: tb/tb_demux_1x8_32bit_buf.sv
// Self-checking bench for demux_1x8_32bit_buf against a per-lane array reference model.
module tb_demux_1x8_32bit_buf;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [31:0]  in_data;
   logic [2:0]   in_select;
   logic         in_bcast;
   logic [7:0]   out_valid;
   logic [7:0]   out_ready;
   logic [255:0] out_data;
   logic [15:0]  accept_cnt;

   int checks = 0;
   int errors = 0;

   // Reference model: contents of each lane buffer and the handshake count.
   logic        m_valid [8];
   logic [31:0] m_data  [8];
   logic [15:0] m_cnt;

   always #5 clk = ~clk;

   demux_1x8_32bit_buf dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_select (in_select),
      .in_bcast  (in_bcast),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .accept_cnt(accept_cnt)
   );

   function automatic logic model_ready();
      if (rst) return 1'b0;
      if (in_bcast) begin
         for (int i = 0; i < 8; i++)
            if (m_valid[i] && !out_ready[i]) return 1'b0;
         return 1'b1;
      end
      return !m_valid[in_select] || out_ready[in_select];
   endfunction

   function automatic logic [7:0] m_vvec();
      logic [7:0] v;
      for (int i = 0; i < 8; i++) v[i] = m_valid[i];
      return v;
   endfunction

   function automatic logic [255:0] m_dvec();
      logic [255:0] d;
      for (int i = 0; i < 8; i++) d[i*32 +: 32] = m_data[i];
      return d;
   endfunction

   // Advance one clock, updating the model from the inputs held across the edge.
   task automatic tick();
      logic acc;
      acc = in_valid && model_ready();
      @(posedge clk);
      if (rst) begin
         for (int i = 0; i < 8; i++) begin
            m_valid[i] = 1'b0;
            m_data[i]  = '0;
         end
         m_cnt = '0;
      end else begin
         for (int i = 0; i < 8; i++) begin
            if (acc && (in_bcast || in_select == 3'(i))) begin
               m_valid[i] = 1'b1;
               m_data[i]  = in_data;
            end else if (m_valid[i] && out_ready[i]) begin
               m_valid[i] = 1'b0;
            end
         end
         if (acc) m_cnt = m_cnt + 16'd1;
      end
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b1; in_data = 32'h1234_5678; in_select = 3'd2;
      in_bcast = 1'b0; out_ready = 8'hFF;
      for (int c = 0; c < 2; c++) begin
         #1;
         checks++;
         if (in_ready !== 1'b0) begin
            errors++; $display("FAIL reset_in_ready: got %b want 0", in_ready);
         end
         tick();
      end
      checks++;
      if (out_valid !== 8'h00) begin
         errors++; $display("FAIL reset_out_valid: got %h want 00", out_valid);
      end
      checks++;
      if (out_data !== 256'd0) begin
         errors++; $display("FAIL reset_out_data: got %h want 0", out_data);
      end
      checks++;
      if (accept_cnt !== 16'd0) begin
         errors++; $display("FAIL reset_cnt: got %h want 0", accept_cnt);
      end
      rst = 1'b0; in_valid = 1'b0;
   endtask

   task automatic test_unicast_sweep();
      out_ready = 8'hFF; in_bcast = 1'b0;
      for (int k = 0; k < 8; k++) begin
         in_valid = 1'b1; in_select = 3'(k); in_data = 32'(k + 1);
         #1;
         checks++;
         if (in_ready !== 1'b1) begin
            errors++; $display("FAIL sweep_ready lane %0d: got %b want 1", k, in_ready);
         end
         tick();
         checks++;
         if (out_valid !== (8'h01 << k) || out_data[k*32 +: 32] !== 32'(k + 1)) begin
            errors++;
            $display("FAIL sweep_lane %0d: valid %h data %h want valid %h data %h", k,
                     out_valid, out_data[k*32 +: 32], 8'h01 << k, k + 1);
         end
      end
      in_valid = 1'b0;
      tick();
      checks++;
      if (accept_cnt !== 16'd8 || out_valid !== 8'h00) begin
         errors++;
         $display("FAIL sweep_cnt: cnt %0d valid %h want cnt 8 valid 00", accept_cnt, out_valid);
      end
   endtask

   task automatic test_backpressure();
      out_ready = 8'h00; in_bcast = 1'b0; in_select = 3'd3;
      in_valid = 1'b1; in_data = 32'hA5A5_0001;
      tick();
      in_data = 32'hA5A5_0002;
      #1;
      checks++;
      if (in_ready !== 1'b0) begin
         errors++; $display("FAIL bp_stall: in_ready %b want 0", in_ready);
      end
      tick();
      checks++;
      if (out_valid[3] !== 1'b1 || out_data[3*32 +: 32] !== 32'hA5A5_0001) begin
         errors++;
         $display("FAIL bp_hold: valid %b data %h want 1 a5a50001", out_valid[3],
                  out_data[3*32 +: 32]);
      end
      out_ready[3] = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
         errors++; $display("FAIL bp_release: in_ready %b want 1", in_ready);
      end
      tick();
      in_valid = 1'b0;
      checks++;
      if (out_valid[3] !== 1'b1 || out_data[3*32 +: 32] !== 32'hA5A5_0002) begin
         errors++;
         $display("FAIL bp_replace: valid %b data %h want 1 a5a50002", out_valid[3],
                  out_data[3*32 +: 32]);
      end
      tick();
   endtask

   task automatic test_broadcast();
      logic [15:0]  cnt0;
      logic [255:0] snap;
      out_ready = 8'h00; in_bcast = 1'b0; in_valid = 1'b1;
      in_select = 3'd5; in_data = 32'h0000_0055;
      tick();
      out_ready = 8'hDF;
      in_bcast = 1'b1; in_data = 32'hDEAD_BEEF; in_select = 3'd0;
      cnt0 = accept_cnt; snap = out_data;
      #1;
      checks++;
      if (in_ready !== 1'b0) begin
         errors++; $display("FAIL bcast_blocked: in_ready %b want 0", in_ready);
      end
      tick();
      checks++;
      if (out_data !== snap || out_valid !== 8'h20 || accept_cnt !== cnt0) begin
         errors++;
         $display("FAIL bcast_nochange: valid %h cnt %0d want valid 20 cnt %0d", out_valid,
                  accept_cnt, cnt0);
      end
      out_ready = 8'hFF;
      tick();
      in_valid = 1'b0; in_bcast = 1'b0;
      checks++;
      if (out_valid !== 8'hFF || out_data !== {8{32'hDEAD_BEEF}} || accept_cnt !== cnt0 + 16'd1)
      begin
         errors++;
         $display("FAIL bcast_all: valid %h data %h cnt %0d want ff deadbeef x8 cnt %0d",
                  out_valid, out_data, accept_cnt, cnt0 + 16'd1);
      end
      tick();
   endtask

   task automatic test_back_to_back();
      logic [15:0] cnt0;
      logic [31:0] base;
      int          bad;
      base = $urandom; cnt0 = accept_cnt; bad = 0;
      out_ready = 8'h40; in_bcast = 1'b0; in_select = 3'd6; in_valid = 1'b1;
      for (int k = 0; k < 20; k++) begin
         in_data = base + 32'(k);
         #1;
         if (in_ready !== 1'b1) bad++;
         tick();
         if (out_valid[6] !== 1'b1 || out_data[6*32 +: 32] !== base + 32'(k)) bad++;
      end
      in_valid = 1'b0;
      checks++;
      if (bad != 0) begin
         errors++; $display("FAIL b2b_stream: %0d bubble/order errors want 0", bad);
      end
      checks++;
      if (accept_cnt !== cnt0 + 16'd20) begin
         errors++; $display("FAIL b2b_cnt: got %0d want %0d", accept_cnt, cnt0 + 16'd20);
      end
      tick();
   endtask

   task automatic test_random();
      for (int c = 0; c < 400; c++) begin
         in_valid  = 1'($urandom_range(0, 3) != 0);
         in_bcast  = 1'($urandom_range(0, 7) == 0);
         in_select = 3'($urandom);
         in_data   = $urandom;
         out_ready = 8'($urandom);
         #1;
         checks++;
         if (in_ready !== model_ready()) begin
            errors++; $display("FAIL rand_ready cyc %0d: got %b want %b", c, in_ready,
                               model_ready());
         end
         tick();
         checks++;
         if (out_valid !== m_vvec() || out_data !== m_dvec() || accept_cnt !== m_cnt) begin
            errors++;
            $display("FAIL rand_state cyc %0d: valid %h cnt %0d want valid %h cnt %0d", c,
                     out_valid, accept_cnt, m_vvec(), m_cnt);
         end
      end
      in_valid = 1'b0;
   endtask

   task automatic test_reset_mid_and_wrap();
      out_ready = 8'h00; in_bcast = 1'b0; in_valid = 1'b1;
      in_select = 3'd0; in_data = 32'h1111_0000; tick();
      in_select = 3'd2; in_data = 32'h2222_0000; tick();
      rst = 1'b1; in_select = 3'd4;
      tick();
      rst = 1'b0; in_valid = 1'b0;
      checks++;
      if (out_valid !== 8'h00 || out_data !== 256'd0 || accept_cnt !== 16'd0) begin
         errors++;
         $display("FAIL mid_reset: valid %h cnt %0d want 00 0", out_valid, accept_cnt);
      end
      out_ready = 8'hFF; in_select = 3'd0; in_valid = 1'b1;
      for (int k = 0; k < 65535; k++) begin
         in_data = 32'(k);
         tick();
      end
      in_valid = 1'b0;
      checks++;
      if (accept_cnt !== 16'hFFFF) begin
         errors++; $display("FAIL cnt_preset: got %h want ffff", accept_cnt);
      end
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      checks++;
      if (accept_cnt !== 16'h0000) begin
         errors++; $display("FAIL cnt_wrap: got %h want 0000", accept_cnt);
      end
   endtask

   initial begin
      for (int i = 0; i < 8; i++) begin
         m_valid[i] = 1'b0;
         m_data[i]  = '0;
      end
      m_cnt = '0;
      test_reset();
      test_unicast_sweep();
      test_backpressure();
      test_broadcast();
      test_back_to_back();
      test_random();
      test_reset_mid_and_wrap();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
